// File: rtl/phi_coef_engine.sv
// phi_coef_engine: per-formant exact a/b linear-prediction coefficients with one shared multiplier and a serial divider.
module phi_coef_engine #(
  parameter int BIT_WIDTH = 32,
  parameter int FORMANTS  = 5,
  parameter int FRAC_BITS = 16,
  parameter int DIFF_MODE = 1
) (
  input  logic                                              clk_in,
  input  logic                                              rst_in,
  input  logic signed [BIT_WIDTH-1:0]                       T_vals [0:2],
  input  logic                                              input_start,
  input  logic                                              input_valid,
  output logic                                              busy,
  output logic signed [BIT_WIDTH-1:0]                       out_a,
  output logic signed [BIT_WIDTH-1:0]                       out_b,
  output logic [(FORMANTS > 1 ? $clog2(FORMANTS) : 1)-1:0]  out_index,
  output logic                                              out_last,
  output logic                                              out_div_zero,
  output logic                                              out_sat,
  output logic                                              out_valid,
  input  logic                                              out_ready
);
  localparam int BW = BIT_WIDTH;
  localparam int RW = BW + 1;
  localparam int PW = 2 * BW + 2;
  localparam int DW = 2 * BW + 3;
  localparam int Q  = DW + FRAC_BITS;
  localparam int IW = FORMANTS > 1 ? $clog2(FORMANTS) : 1;
  localparam int TW = $clog2(Q + 1);
  localparam logic [IW-1:0] LAST = IW'(FORMANTS - 1);
  localparam logic [TW-1:0] QEND = TW'(Q);
  localparam logic [TW-1:0] MEND = TW'(4);
  localparam logic [Q-1:0]  MAXP = {{(Q-BW+1){1'b0}}, {(BW-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, COLLECT, DIFF, MUL, COMB, DIV_A, DIV_B, OUT} state_t;
  state_t state, next;

  logic signed [BW-1:0] storage [0:FORMANTS-1][0:2];
  logic signed [RW-1:0] r [0:2];
  logic signed [RW-1:0] r_new [0:2];
  logic signed [PW-1:0] m [0:4];
  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] mx, my;
  logic signed [DW-1:0] den, an, bn, num;
  logic [DW-1:0] num_mag, den_mag, dvs, rem;
  logic [DW:0] rem_sh, diff_sh;
  logic [Q-1:0] dvd, q_next, lim;
  logic [IW-1:0] cnt, k, kp;
  logic [TW-1:0] it;
  logic neg, ge, sat_now;
  logic signed [BW-1:0] val;

  assign busy      = state != IDLE;
  assign out_valid = state == OUT;
  assign out_last  = state == OUT && k == LAST;
  assign out_index = k;

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = input_start ? COLLECT : IDLE;
      COLLECT: next = (input_valid && cnt == LAST) ? DIFF : COLLECT;
      DIFF:    next = MUL;
      MUL:     next = it == MEND ? COMB : MUL;
      COMB:    next = DIV_A;
      DIV_A:   next = it == QEND ? DIV_B : DIV_A;
      DIV_B:   next = it == QEND ? OUT : DIV_B;
      OUT:     next = out_ready ? (k == LAST ? IDLE : DIFF) : OUT;
      default: next = IDLE;
    endcase
  end

  // r is one bit wider than T so the beat-to-beat difference never wraps
  always_comb begin
    kp = k - IW'(k != '0);
    for (int i = 0; i < 3; i++)
      r_new[i] = {storage[k][i][BW-1], storage[k][i]} -
                 ((DIFF_MODE != 0 && k != '0) ? {storage[kp][i][BW-1], storage[kp][i]} : '0);
  end

  always_comb begin
    mx   = (it == TW'(1) || it == TW'(3)) ? r[1] : r[0];
    my   = it == '0 ? r[0] : (it == TW'(3) || it == MEND) ? r[2] : r[1];
    prod = $signed({{(BW+1){mx[RW-1]}}, mx}) * $signed({{(BW+1){my[RW-1]}}, my});
  end

  // restoring divide step plus sign/saturation of the quotient it produces
  always_comb begin
    num     = state == DIV_A ? an : bn;
    num_mag = num[DW-1] ? -num : num;
    den_mag = den[DW-1] ? -den : den;
    rem_sh  = {rem, dvd[Q-1]};
    diff_sh = rem_sh - {1'b0, dvs};
    ge      = !diff_sh[DW];
    q_next  = {dvd[Q-2:0], ge};
    lim     = MAXP + Q'(neg);
    sat_now = q_next > lim;
    val     = sat_now ? (neg ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}})
                      : (neg ? -q_next[BW-1:0] : q_next[BW-1:0]);
  end

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      cnt          <= '0;
      k            <= '0;
      it           <= '0;
      out_a        <= '0;
      out_b        <= '0;
      out_div_zero <= 1'b0;
      out_sat      <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (input_start) begin cnt <= '0; k <= '0; end
        COLLECT: if (input_valid) cnt <= cnt + 1'b1;
        DIFF:    begin it <= '0; out_div_zero <= 1'b0; out_sat <= 1'b0; end
        MUL:     it <= it == MEND ? '0 : it + 1'b1;
        DIV_A, DIV_B: begin
          it <= it == QEND ? '0 : it + 1'b1;
          if (it == '0 && state == DIV_A) out_div_zero <= den == '0;
          if (it == QEND) begin
            if (state == DIV_A) out_a <= out_div_zero ? '0 : val;
            else out_b <= out_div_zero ? '0 : val;
            out_sat <= out_sat | (sat_now & ~out_div_zero);
          end
        end
        OUT:     if (out_ready && k != LAST) k <= k + 1'b1;
        default: ;
      endcase
    end

  always_ff @(posedge clk_in) begin
    if (state == COLLECT && input_valid)
      for (int i = 0; i < 3; i++) storage[cnt][i] <= T_vals[i];
    if (state == DIFF)
      for (int i = 0; i < 3; i++) r[i] <= r_new[i];
    if (state == MUL) m[it[2:0]] <= prod;
    if (state == COMB) begin
      den <= {m[0][PW-1], m[0]} - {m[1][PW-1], m[1]};
      an  <= {m[2][PW-1], m[2]} - {m[3][PW-1], m[3]};
      bn  <= {m[1][PW-1], m[1]} - {m[4][PW-1], m[4]};
    end
    if (state == DIV_A || state == DIV_B) begin
      if (it == '0) begin
        rem <= '0;
        dvd <= Q'(num_mag) << FRAC_BITS;
        dvs <= den_mag;
        neg <= num[DW-1] ^ den[DW-1];
      end else begin
        rem <= ge ? diff_sh[DW-1:0] : rem_sh[DW-1:0];
        dvd <= q_next;
      end
    end
  end
endmodule

// File: tb/tb_phi_coef_engine.sv
// tb_phi_coef_engine: randomized and directed checks of phi_coef_engine against an arithmetic reference model.
module tb_phi_coef_engine;
  localparam int BW = 16;
  localparam int F  = 2;
  localparam int FB = 12;
  localparam longint VMAX = (64'sd1 <<< (BW - 1)) - 1;
  localparam longint VMIN = -(64'sd1 <<< (BW - 1));

  typedef struct {
    longint a;
    longint b;
    int     idx;
    bit     last;
    bit     dz;
    bit     sat;
  } exp_t;

  logic clk_in = 0, rst_in = 1, input_start = 0, input_valid = 0, out_ready = 1;
  logic signed [BW-1:0] t_in [0:2];
  logic busy, out_last, out_div_zero, out_sat, out_valid;
  logic signed [BW-1:0] out_a, out_b;
  logic [0:0] out_index;
  logic signed [BW-1:0] bt [0:F-1][0:2];
  exp_t expq[$];
  exp_t ce;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_edge = 0;

  phi_coef_engine #(.BIT_WIDTH(BW), .FORMANTS(F), .FRAC_BITS(FB), .DIFF_MODE(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .T_vals(t_in), .input_start(input_start),
    .input_valid(input_valid), .busy(busy), .out_a(out_a), .out_b(out_b),
    .out_index(out_index), .out_last(out_last), .out_div_zero(out_div_zero),
    .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic longint qdiv(longint n, longint d, output bit s);
    longint q, v;
    q = ((n < 0 ? -n : n) <<< FB) / (d < 0 ? -d : d);
    v = ((n < 0) != (d < 0)) ? -q : q;
    s = 0;
    if (v > VMAX) begin v = VMAX; s = 1; end
    else if (v < VMIN) begin v = VMIN; s = 1; end
    return v;
  endfunction

  function automatic exp_t model(int k);
    exp_t e;
    longint r [3];
    longint den, an, bn;
    bit sa, sb;
    for (int i = 0; i < 3; i++) begin
      r[i] = longint'(bt[k][i]);
      if (k > 0) r[i] -= longint'(bt[k-1][i]);
    end
    den = r[0]*r[0] - r[1]*r[1];
    an  = r[0]*r[1] - r[1]*r[2];
    bn  = r[1]*r[1] - r[0]*r[2];
    e.idx = k; e.last = (k == F - 1); e.dz = (den == 0);
    e.a = 0; e.b = 0; e.sat = 0;
    if (!e.dz) begin
      e.a = qdiv(an, den, sa);
      e.b = qdiv(bn, den, sb);
      e.sat = sa | sb;
    end
    return e;
  endfunction

  always @(negedge clk_in)
    if (!rst_in && out_valid) begin
      n_cmp++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_result: out_valid=1 a=%0d b=%0d with no result expected", out_a, out_b);
      end else begin
        ce = expq[0];
        if (longint'(out_a) != ce.a || longint'(out_b) != ce.b || int'(out_index) != ce.idx ||
            out_last !== ce.last || out_div_zero !== ce.dz || out_sat !== ce.sat || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL result_k%0d: got a=%0d b=%0d idx=%0d last=%0d dz=%0d sat=%0d busy=%0d, required a=%0d b=%0d idx=%0d last=%0d dz=%0d sat=%0d busy=1",
                   ce.idx, out_a, out_b, out_index, out_last, out_div_zero, out_sat, busy,
                   ce.a, ce.b, ce.idx, ce.last, ce.dz, ce.sat);
        end
        if (out_ready) void'(expq.pop_front());
      end
    end

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic check_zero(input string nm);
    check(nm, {busy, out_valid, out_a, out_b, out_index, out_last, out_div_zero, out_sat}, 0);
  endtask

  task automatic set_bt(input int a0, a1, a2, b0, b1, b2);
    bt[0][0] = 16'(a0); bt[0][1] = 16'(a1); bt[0][2] = 16'(a2);
    bt[1][0] = 16'(b0); bt[1][1] = 16'(b1); bt[1][2] = 16'(b2);
  endtask

  task automatic send_frame(input bit junk_with_start);
    @(posedge clk_in); #1;
    input_start = 1;
    input_valid = junk_with_start;
    t_in[0] = 16'sd100; t_in[1] = -16'sd50; t_in[2] = 16'sd7;
    @(posedge clk_in); #1;
    input_start = 0;
    for (int k = 0; k < F; k++) begin
      input_valid = 1;
      for (int i = 0; i < 3; i++) t_in[i] = bt[k][i];
      @(posedge clk_in); #1;
    end
    input_valid = 0;
    last_edge = cyc;
    for (int k = 0; k < F; k++) expq.push_back(model(k));
  endtask

  task automatic wait_valid(input string nm);
    bit ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk_in);
      ok = out_valid;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: out_valid still 0 after 1000 cycles, required 1", nm);
    end
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 3000 && expq.size() != 0; i++) begin
      @(posedge clk_in); #1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    check("drain_pending", expq.size(), 0);
    out_ready = 1;
  endtask

  initial begin
    int t1;
    bit stable, seen;
    logic signed [BW-1:0] ha, hb;
    for (int i = 0; i < 3; i++) t_in[i] = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check_zero("reset_outputs");
    rst_in = 0;

    set_bt(4, 2, 1, 7, 3, 1);
    send_frame(0);
    wait_valid("c1_first");
    check("c1_latency", cyc - last_edge, 103);
    check("c1_a0", out_a, 2048);
    check("c1_b0", out_b, 0);
    check("c1_idx0", out_index, 0);
    t1 = cyc;
    wait_valid("c1_second");
    check("c1_spacing", cyc - t1, 104);
    check("c1_a1", out_a, 1536);
    check("c1_b1", out_b, 512);
    check("c1_idx1", out_index, 1);
    check("c1_last1", out_last, 1);
    @(negedge clk_in);
    check("c1_busy_fall", busy, 0);

    set_bt(1, 2, 0, 5, 5, 5);
    send_frame(0);
    wait_valid("c2");
    check("c2_a", out_a, -2730);
    check("c2_b", out_b, -5461);
    check("c2_sat", out_sat, 0);
    drain(0);

    set_bt(3, 3, 5, 1, 1, 1);
    send_frame(0);
    wait_valid("c3");
    check("c3_latency", cyc - last_edge, 103);
    check("c3_ab", {out_a, out_b}, 0);
    check("c3_div_zero", out_div_zero, 1);
    drain(0);

    set_bt(3, 2, -100, 0, 0, 0);
    send_frame(0);
    wait_valid("c4");
    check("c4_a", out_a, 32767);
    check("c4_b", out_b, 32767);
    check("c4_sat", out_sat, 1);
    drain(0);

    out_ready = 0;
    set_bt(4, 2, 1, 7, 3, 1);
    send_frame(1);
    repeat (10) @(posedge clk_in);
    #1;
    input_start = 1; input_valid = 1;
    @(posedge clk_in); #1;
    input_start = 0; input_valid = 0;
    wait_valid("c5");
    check("c5_a_after_ignored", out_a, 2048);
    ha = out_a; hb = out_b; stable = 1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk_in); #1;
      input_start = (j == 3); input_valid = (j == 3);
      @(negedge clk_in);
      if (!out_valid || out_a !== ha || out_b !== hb || out_index !== 1'b0) stable = 0;
    end
    check("c5_hold_stable", stable, 1);
    @(posedge clk_in); #1;
    out_ready = 1;
    drain(0);

    send_frame(0);
    repeat (17) @(posedge clk_in);
    #1;
    rst_in = 1;
    #1;
    check_zero("c6_reset_outputs");
    expq.delete();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 0;
    seen = 0;
    repeat (150) begin
      @(negedge clk_in);
      seen |= out_valid;
    end
    check("c6_no_result", seen, 0);
    send_frame(0);
    wait_valid("c6_first");
    check("c6_latency", cyc - last_edge, 103);
    check("c6_a0", out_a, 2048);
    wait_valid("c6_second");
    check("c6_a1", out_a, 1536);
    check("c6_b1", out_b, 512);
    drain(0);

    for (int f = 0; f < 25; f++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int k = 0; k < F; k++)
        for (int i = 0; i < 3; i++)
          bt[k][i] = mode == 0 ? 16'($urandom) : 16'(int'($urandom_range(0, 8)) - 4);
      send_frame(0);
      drain(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
